// File: rtl/down_counter.sv
// down_counter: synchronous loadable down-counter / timer with a one-cycle
// terminal-count pulse. All state changes on one rising edge of CLK, so Q is
// glitch-free.
//
// Build option: define DOWN_COUNTER_AUTORELOAD_EN for periodic mode. On
// expiry Q reloads from RLD and the counter keeps running. With the macro
// undefined the counter is one-shot: it parks at 0 in IDLE until the next load.
//
// Ports:
//   CLK   in   clock, rising edge
//   RST   in   synchronous active-high reset
//   LD    in   load strobe (priority over EN)
//   D     in   [WIDTH] load value
//   EN    in   count enable, only honoured in RUN
//   Q     out  [WIDTH] current count (registered)
//   TC    out  terminal-count pulse, one cycle (registered)
//   BUSY  out  high while in RUN (registered)

module down_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             BUSY
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_d;
    logic [WIDTH-1:0] rld;
    logic [WIDTH-1:0] rld_d;
    logic [WIDTH-1:0] q_d;
    logic             tc_d;
    logic             busy_d;
    logic             expire_c;

    // Enabled edge in RUN with Q at 1 ends the period.
    assign expire_c = (state == RUN) && EN && (Q == WIDTH'(1));

    // State and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            Q     <= '0;
            rld   <= '0;
            TC    <= 1'b0;
            BUSY  <= 1'b0;
        end else begin
            state <= state_d;
            Q     <= q_d;
            rld   <= rld_d;
            TC    <= tc_d;
            BUSY  <= busy_d;
        end
    end

    // Next state: a load picks RUN/IDLE from D; expiry decides by build mode.
    always_comb begin
        state_d = state;
        if (LD) begin
            state_d = (D != '0) ? RUN : IDLE;
        end else if (expire_c) begin
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            state_d = RUN;
`else
            state_d = IDLE;
`endif
        end
    end

    // Next output values; a load wins over expiry and suppresses TC.
    always_comb begin
        q_d    = Q;
        rld_d  = rld;
        tc_d   = 1'b0;
        busy_d = (state_d == RUN);
        if (LD) begin
            q_d   = D;
            rld_d = D;
        end else if (expire_c) begin
            tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTORELOAD_EN
            q_d  = rld;
`else
            q_d  = '0;
`endif
        end else if ((state == RUN) && EN && (Q > WIDTH'(1))) begin
            // Decrement only from 2 upward so Q can never wrap below 0.
            q_d = Q - WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_down_counter.sv
// Directed testbench for down_counter (WIDTH=4). Expected values are written
// out by hand; expiry expectations follow DOWN_COUNTER_AUTORELOAD_EN.

module tb_down_counter;

    localparam int unsigned WIDTH = 4;

    logic             clk;
    logic             rst;
    logic             ld;
    logic [WIDTH-1:0] d;
    logic             en;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             busy;

    int vectors;
    int miscompares;

    down_counter #(.WIDTH(WIDTH)) dut (
        .CLK  (clk),
        .RST  (rst),
        .LD   (ld),
        .D    (d),
        .EN   (en),
        .Q    (q),
        .TC   (tc),
        .BUSY (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: count it and report a mismatch.
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int eq, input int etc, input int ebusy);
        check({tag, ".q"},    16'(q),    16'(eq));
        check({tag, ".tc"},   16'(tc),   16'(etc));
        check({tag, ".busy"}, 16'(busy), 16'(ebusy));
    endtask

    // Drive inputs away from the edge, take one rising edge, settle.
    task automatic tick(input logic r, input logic l, input logic [WIDTH-1:0] dv, input logic e);
        @(negedge clk);
        rst = r;
        ld  = l;
        d   = dv;
        en  = e;
        @(posedge clk);
        #1;
    endtask

    int tc_count;
    int last_tc;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst = 1'b0;
        ld  = 1'b0;
        d   = '0;
        en  = 1'b0;

        // Reset dominates load and enable.
        tick(1'b1, 1'b1, 4'd9, 1'b1); expect_out("rst0", 0, 0, 0);
        tick(1'b1, 1'b1, 4'd9, 1'b1); expect_out("rst1", 0, 0, 0);
        tick(1'b0, 1'b0, 4'd0, 1'b0); expect_out("rst_hold0", 0, 0, 0);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("rst_hold1", 0, 0, 0);

        // Load 3 then count with EN held.
        tick(1'b0, 1'b1, 4'd3, 1'b1); expect_out("ld3", 3, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("cnt2", 2, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("cnt1", 1, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        expect_out("exp3", 3, 1, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("after_exp3", 2, 0, 1);
`else
        expect_out("exp3", 0, 1, 0);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("park0", 0, 0, 0);
        end
`endif

        // Enable gaps stretch the period.
        tick(1'b0, 1'b1, 4'd2, 1'b0); expect_out("gap_ld2", 2, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("gap_e1", 1, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b0); expect_out("gap_e0a", 1, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b0); expect_out("gap_e0b", 1, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        expect_out("gap_exp", 2, 1, 1);
`else
        expect_out("gap_exp", 0, 1, 0);
`endif

        // Load beats expiry; loading 0 idles without TC.
        tick(1'b0, 1'b1, 4'd2, 1'b0); expect_out("pri_ld2", 2, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("pri_q1", 1, 0, 1);
        tick(1'b0, 1'b1, 4'd5, 1'b1); expect_out("pri_ld5", 5, 0, 1);
        tick(1'b0, 1'b1, 4'd0, 1'b1); expect_out("pri_ld0", 0, 0, 0);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("idle_en", 0, 0, 0);

        // Back-to-back loads: no decrement while LD is high.
        tick(1'b0, 1'b1, 4'd7, 1'b1); expect_out("b2b_ld7", 7, 0, 1);
        tick(1'b0, 1'b1, 4'd6, 1'b1); expect_out("b2b_ld6", 6, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("b2b_dec", 5, 0, 1);

        // Maximum period: load 15, TC exactly on the 15th enabled edge.
        tick(1'b0, 1'b1, 4'd15, 1'b0); expect_out("max_ld", 15, 0, 1);
        for (int i = 1; i < 15; i++) begin
            tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("max_cnt", 15 - i, 0, 1);
        end
        tick(1'b0, 1'b0, 4'd0, 1'b1);
`ifdef DOWN_COUNTER_AUTORELOAD_EN
        expect_out("max_exp", 15, 1, 1);
`else
        expect_out("max_exp", 0, 1, 0);
`endif

        // Reset mid-count at Q=7.
        tick(1'b0, 1'b1, 4'd10, 1'b0); expect_out("mid_ld10", 10, 0, 1);
        tick(1'b0, 1'b0, 4'd0, 1'b1);
        tick(1'b0, 1'b0, 4'd0, 1'b1);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("mid_q7", 7, 0, 1);
        tick(1'b1, 1'b0, 4'd0, 1'b1); expect_out("mid_rst", 0, 0, 0);
        tick(1'b0, 1'b0, 4'd0, 1'b1); expect_out("mid_after", 0, 0, 0);

        // Reset on the would-be expiry edge drops the pending TC.
        tick(1'b0, 1'b1, 4'd1, 1'b0); expect_out("lost_ld1", 1, 0, 1);
        tick(1'b1, 1'b0, 4'd0, 1'b1); expect_out("lost_tc", 0, 0, 0);

`ifdef DOWN_COUNTER_AUTORELOAD_EN
        // Periodic: load 4, twelve enabled cycles, three TC pulses 4 apart.
        tick(1'b0, 1'b1, 4'd4, 1'b0); expect_out("ar_ld4", 4, 0, 1);
        tc_count = 0;
        last_tc  = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b0, 4'd0, 1'b1);
            expect_out("ar_cnt", ((i % 4) == 0) ? 4 : 4 - (i % 4),
                       ((i % 4) == 0) ? 1 : 0, 1);
            if (tc == 1'b1) begin
                if (tc_count > 0) check("ar_gap", 16'(i - last_tc), 16'd4);
                tc_count++;
                last_tc = i;
            end
        end
        check("ar_pulses", 16'(tc_count), 16'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/down_counter.md
# down_counter

Synchronous, loadable down-counter and timer. It is the counting-down counterpart to the team's 4-bit JK ripple up-counter. A value loaded on D is decremented once per enabled CLK edge. A one-cycle terminal-count pulse (TC) is raised when the count expires. All state changes on one clock edge, with no ripple, so Q is glitch-free and safe to compare downstream.

## Interface

Parameters:
- WIDTH, default 4: counter width in bits; legal range 2–16.

Ports:
- CLK  input  1  single clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous, active-high.
- LD  input  1  load strobe; highest priority after RST.
- D  input  WIDTH  load value, sampled when LD=1.
- EN  input  1  count enable; ignored outside RUN.
- Q  output  WIDTH  current count, registered.
- TC  output  1  terminal-count pulse, registered, one cycle wide.
- BUSY  output  1  high while in RUN, registered.

## Operation

- Internal state: the FSM (IDLE, RUN), the count register driving Q, and the reload register RLD (WIDTH bits).
- Priority at each rising edge is RST, then LD, then EN.
- RST=1 sets:
  - state=IDLE, Q=0, RLD=0, TC=0, BUSY=0.
- LD=1 (any state) sets:
  - Q=D, RLD=D, TC=0.
  - If D≠0: state=RUN, BUSY=1.
  - If D=0: state=IDLE, BUSY=0, and no TC is generated.
- RUN, LD=0, EN=0: Q, state and BUSY hold; TC=0.
- RUN, LD=0, EN=1, Q>1: Q=Q−1, TC=0.
- RUN, LD=0, EN=1, Q=1: TC=1 for this cycle. The next-state behaviour depends on configuration (see below).
- IDLE, LD=0: Q holds and TC=0. EN has no effect.
- Arithmetic is unsigned modulo 2^WIDTH. Q never underflows: the decrement is only applied when Q≥2, so Q never goes from 0 to all-ones.
- Loading all-ones (e.g. 15 for WIDTH=4) is legal and gives the maximum period of 2^WIDTH−1 enabled cycles.
- LD asserted on the same edge as the expiry beats expiry: the load is applied and TC stays 0.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- LD sampled at edge k gives Q=D after edge k.
  - The first decrement happens at edge k+1 if EN=1.
- After a load of value N with EN held high, TC=1 appears after edge k+N, lasting exactly one cycle.
  - So the count takes N enabled edges.
- EN gaps stretch the period one-for-one. TC is tied to the N-th enabled edge, not to wall-clock cycles.
- BUSY changes on the same edge as the corresponding state change.
- If RST is asserted mid-count, all outputs read reset values after that edge. Any pending TC is lost.
- Back-to-back LD on consecutive edges: each load overwrites the previous one. No decrement happens on any edge where LD=1.

## Configuration

- Macro: DOWN_COUNTER_AUTORELOAD_EN.
- Undefined (one-shot):
  - On expiry, Q=0, state=IDLE, BUSY=0.
  - The counter stays at 0 until the next LD.
- Defined (periodic):
  - On expiry, Q=RLD, state stays RUN, BUSY stays 1.
  - TC then pulses every RLD enabled cycles.
  - Q never shows 0 while running.
  - RLD changes only on LD or RST.
- Macro-independent behaviour:
  - Loading 0 goes to IDLE in both builds.
  - Reset values are identical in both builds.

## Test plan

- Reset: hold RST=1 for 2 cycles with LD=1, D=9, EN=1 → Q=0, TC=0, BUSY=0 after each edge. Then RST=0 with LD=0 → outputs hold at 0.
- One-shot, WIDTH=4 (macro undefined): LD with D=3, then EN=1 held → Q goes 3,2,1,0 on successive edges; TC=1 only in the cycle where Q=0; BUSY drops on that same edge; Q stays 0 for 5 further cycles.
- Enable gaps: load D=2, then EN pattern 1,0,0,1 → Q goes 2,1,1,1,0, with TC high only in the final cycle.
- Load priority: while in RUN at Q=1 with EN=1, assert LD with D=5 → Q=5, TC=0, BUSY=1. Also load D=0 → Q=0, BUSY=0, TC=0.
- Autoreload (macro defined): load D=4, EN held for 12 cycles → Q cycles 4,3,2,1,4,3,2,1,4,… and TC pulses exactly three times, 4 cycles apart.
- Boundary: WIDTH=4, load D=15, EN held → TC after exactly 15 edges. Then apply RST during a later count at Q=7 → Q=0 next edge and no TC.
